hwpe_ctrl_job_dispatcher: RTL and testbench
===========================================

// Module: hwpe_ctrl_job_dispatcher
// PURPOSE
//  Master-side counterpart of the HWPE control slave: issues peripheral-bus reads/writes that
//  acquire a context, program job registers, trigger, optionally poll until idle. Sits between a
//  local job source (DMA/sequencer/test core) and an HWPE periph port; replaces core-driven setup.
// PARAMETERS
//  N_JOB_REGS    16     max job registers per job (word-addressed, contiguous)
//  JOB_BASE_OFFS 32'h20 byte offset of first job register (after mandatory regs)
//  BACKOFF_CYC   8      idle cycles between failed acquire and retry (>=1)
//  ID_WIDTH      8      periph transaction id width
// PORTS
//  clk_i           in  1               clock
//  rst_ni          in  1               async reset, active low
//  clear_i         in  1               sync soft clear / abort
//  base_addr_i     in  32              HWPE periph base address, static
//  job_valid_i     in  1               job offered
//  job_ready_o     out 1               job accepted when valid&ready
//  job_nregs_i     in  $clog2(N+1)     registers to write (0..N_JOB_REGS)
//  job_regs_i      in  N_JOB_REGS*32   register values, index 0 first
//  periph_req_o    out 1               request
//  periph_gnt_i    in  1               grant
//  periph_add_o    out 32              byte address
//  periph_wen_o    out 1               0=write, 1=read
//  periph_be_o     out 4               byte enables, always 4'hF
//  periph_data_o   out 32              write data
//  periph_id_o     out ID_WIDTH        transaction id
//  periph_r_valid_i in 1               response valid
//  periph_r_data_i in  32              response data
//  busy_o          out 1               FSM not IDLE
//  job_id_o        out 8               id returned by acquire, valid while busy_o
//  done_o          out 1               1-cycle pulse on job completion
// BEHAVIOUR
//  Reset: all outputs 0, except periph_wen_o=1 and periph_be_o=4'hF. State IDLE.
//  Bus: one outstanding transaction. req/add/wen/data/id held stable until gnt.
//   Every transaction, write or read, completes on r_valid, earliest 1 cycle after gnt.
//   periph_id_o increments mod 2^ID_WIDTH per granted transaction.
//  FSM:
//   IDLE: job_ready_o=1. On accept, latch regs; nregs=min(job_nregs_i,N_JOB_REGS) -> ACQ_REQ.
//   ACQ_REQ: read base+0x04 (ACQUIRE) -> ACQ_RSP on gnt.
//   ACQ_RSP on r_valid:
//    rdata[31]=1 (no free context): load backoff cnt=BACKOFF_CYC -> BACKOFF.
//    else job_id_o<=rdata[7:0], idx=0 -> WR_REQ, or TRIG_REQ if nregs==0.
//   BACKOFF: decrement to 0 -> ACQ_REQ.
//   WR_REQ: write regs[idx] to base+JOB_BASE_OFFS+4*idx -> WR_RSP on gnt.
//   WR_RSP on r_valid: idx++. idx==nregs-1 -> TRIG_REQ, else WR_REQ.
//   TRIG_REQ: write 0 to base+0x00 -> TRIG_RSP on gnt.
//   TRIG_RSP on r_valid: -> POLL_REQ (macro on) or FINISH.
//   FINISH: done_o=1 for one cycle -> IDLE.
//  Latency, nregs=K, zero-wait slave, 1-cycle response, acquire success:
//   accept -> done_o = 2*(K+2)+1 cycles.
//  clear_i: granted-but-unanswered transaction -> DRAIN (wait r_valid, no new req) -> IDLE.
//   Else -> IDLE next cycle. No done_o; job_id_o cleared. Ungranted req dropped.
//   clear_i takes priority over all same-cycle events, including job accept.
//  rst_ni mid-job: async return to reset values; slave side is cleaned separately.
// CONFIGURATION
//  HWPE_CTRL_DISPATCH_WAIT_EN defined:
//   POLL_REQ reads base+0x0C (STATUS). POLL_RSP: rdata==0 -> FINISH, else POLL_REQ.
//   done_o means HWPE idle.
//  Undefined: POLL states absent. done_o means trigger accepted by slave.
// STRUCTURE
//  hwpe_ctrl_package: add localparams HWPE_CTRL_OFFS_TRIGGER=0x00, _ACQUIRE=0x04,
//   _STATUS=0x0C, and typedef enum dispatch_state_t.
//  Single module; sub-module not warranted (one FSM plus idx/backoff counters).
// TESTING
//  1 nregs=3, regs={A,B,C}, acquire rdata=0x2, 0-wait
//    -> writes 0x20/0x24/0x28 = A/B/C, trigger write to 0x00, job_id_o=2, done_o at cycle 11.
//  2 acquire rdata=0xFFFFFFFF twice, then 0x1
//    -> 3 acquire reads spaced >= BACKOFF_CYC idle cycles, then normal sequence.
//  3 nregs=0 -> acquire then trigger only. nregs=N+5 -> exactly N_JOB_REGS writes.
//  4 gnt delayed 3 cycles, r_valid delayed 2
//    -> req/add/data stable until gnt, no second req before r_valid.
//  5 clear_i after gnt of write #2, before r_valid
//    -> DRAIN, no req, IDLE after r_valid, no done_o.
//  6 WAIT_EN on, STATUS returns 1,1,0 -> 3 polls, then done_o.
//    WAIT_EN off -> no STATUS read.

Source files
------------

// File: rtl/hwpe_ctrl_package.sv
// Shared constants and state encoding for the HWPE control job dispatcher.
// The POLL states exist only when HWPE_CTRL_DISPATCH_WAIT_EN is defined.
package hwpe_ctrl_package;

  localparam logic [31:0] HWPE_CTRL_OFFS_TRIGGER = 32'h00;
  localparam logic [31:0] HWPE_CTRL_OFFS_ACQUIRE = 32'h04;
  localparam logic [31:0] HWPE_CTRL_OFFS_STATUS  = 32'h0C;

  typedef enum logic [3:0] {
    DS_IDLE,
    DS_ACQ_REQ,
    DS_ACQ_RSP,
    DS_BACKOFF,
    DS_WR_REQ,
    DS_WR_RSP,
    DS_TRIG_REQ,
    DS_TRIG_RSP,
`ifdef HWPE_CTRL_DISPATCH_WAIT_EN
    DS_POLL_REQ,
    DS_POLL_RSP,
`endif
    DS_FINISH,
    DS_DRAIN
  } dispatch_state_t;

endpackage

// File: rtl/hwpe_ctrl_job_dispatcher.sv
// Bus master that acquires an HWPE context, writes job registers and triggers.
// Define HWPE_CTRL_DISPATCH_WAIT_EN to poll STATUS until the HWPE is idle.
module hwpe_ctrl_job_dispatcher
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned N_JOB_REGS    = 16,
  parameter logic [31:0] JOB_BASE_OFFS = 32'h20,
  parameter int unsigned BACKOFF_CYC   = 8,
  parameter int unsigned ID_WIDTH      = 8,
  localparam int unsigned NW = $clog2(N_JOB_REGS + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic [31:0]             base_addr_i,
  input  logic                    job_valid_i,
  output logic                    job_ready_o,
  input  logic [NW-1:0]           job_nregs_i,
  input  logic [N_JOB_REGS*32-1:0] job_regs_i,
  output logic                    periph_req_o,
  input  logic                    periph_gnt_i,
  output logic [31:0]             periph_add_o,
  output logic                    periph_wen_o,
  output logic [3:0]              periph_be_o,
  output logic [31:0]             periph_data_o,
  output logic [ID_WIDTH-1:0]     periph_id_o,
  input  logic                    periph_r_valid_i,
  input  logic [31:0]             periph_r_data_i,
  output logic                    busy_o,
  output logic [7:0]              job_id_o,
  output logic                    done_o
);

  localparam int unsigned IW = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;
  localparam int unsigned CW = $clog2(BACKOFF_CYC + 1);
  localparam logic [NW-1:0] NMAX = NW'(N_JOB_REGS);

  dispatch_state_t state_q, state_d;

  logic [31:0]         regs_q [N_JOB_REGS];
  logic [NW-1:0]       nregs_q, idx_q;
  logic [CW-1:0]       cnt_q;
  logic [7:0]          job_id_q;
  logic [ID_WIDTH-1:0] id_q;
  logic                accept, granted, rsp_pending, last_wr;
  logic                unused_rdata;

  assign accept  = job_valid_i & job_ready_o;
  assign granted = periph_req_o & periph_gnt_i;
  assign last_wr = (idx_q + NW'(1)) == nregs_q;

  // States in which a granted transaction still awaits its response
  assign rsp_pending = (state_q == DS_ACQ_RSP)  |
                       (state_q == DS_WR_RSP)   |
                       (state_q == DS_TRIG_RSP) |
`ifdef HWPE_CTRL_DISPATCH_WAIT_EN
                       (state_q == DS_POLL_RSP) |
`endif
                       (state_q == DS_DRAIN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= DS_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DS_IDLE:     if (job_valid_i) state_d = DS_ACQ_REQ;
      DS_ACQ_REQ:  if (periph_gnt_i) state_d = DS_ACQ_RSP;
      DS_ACQ_RSP: begin
        if (periph_r_valid_i) begin
          if (periph_r_data_i[31])  state_d = DS_BACKOFF;
          else if (nregs_q == '0)   state_d = DS_TRIG_REQ;
          else                      state_d = DS_WR_REQ;
        end
      end
      DS_BACKOFF:  if (cnt_q == CW'(1)) state_d = DS_ACQ_REQ;
      DS_WR_REQ:   if (periph_gnt_i) state_d = DS_WR_RSP;
      DS_WR_RSP: begin
        if (periph_r_valid_i)
          state_d = last_wr ? DS_TRIG_REQ : DS_WR_REQ;
      end
      DS_TRIG_REQ: if (periph_gnt_i) state_d = DS_TRIG_RSP;
`ifdef HWPE_CTRL_DISPATCH_WAIT_EN
      DS_TRIG_RSP: if (periph_r_valid_i) state_d = DS_POLL_REQ;
      DS_POLL_REQ: if (periph_gnt_i) state_d = DS_POLL_RSP;
      DS_POLL_RSP: begin
        if (periph_r_valid_i)
          state_d = (periph_r_data_i == '0) ? DS_FINISH : DS_POLL_REQ;
      end
`else
      DS_TRIG_RSP: if (periph_r_valid_i) state_d = DS_FINISH;
`endif
      DS_FINISH:   state_d = DS_IDLE;
      DS_DRAIN:    if (periph_r_valid_i) state_d = DS_IDLE;
      default:     state_d = DS_IDLE;
    endcase
    // Abort wins over every other event; an answered transaction needs no drain
    if (clear_i)
      state_d = (rsp_pending && !periph_r_valid_i) ? DS_DRAIN : DS_IDLE;
  end

  always_comb begin
    periph_req_o  = 1'b0;
    periph_add_o  = '0;
    periph_wen_o  = 1'b1;
    periph_data_o = '0;
    unique case (state_q)
      DS_ACQ_REQ: begin
        periph_req_o = ~clear_i;
        periph_add_o = base_addr_i + HWPE_CTRL_OFFS_ACQUIRE;
      end
      DS_WR_REQ: begin
        periph_req_o  = ~clear_i;
        periph_add_o  = base_addr_i + JOB_BASE_OFFS + (32'(idx_q) << 2);
        periph_wen_o  = 1'b0;
        periph_data_o = regs_q[idx_q[IW-1:0]];
      end
      DS_TRIG_REQ: begin
        periph_req_o = ~clear_i;
        periph_add_o = base_addr_i + HWPE_CTRL_OFFS_TRIGGER;
        periph_wen_o = 1'b0;
      end
`ifdef HWPE_CTRL_DISPATCH_WAIT_EN
      DS_POLL_REQ: begin
        periph_req_o = ~clear_i;
        periph_add_o = base_addr_i + HWPE_CTRL_OFFS_STATUS;
      end
`endif
      default: ;
    endcase
  end

  assign job_ready_o  = rst_ni & (state_q == DS_IDLE) & ~clear_i;
  assign busy_o       = state_q != DS_IDLE;
  assign done_o       = (state_q == DS_FINISH) & ~clear_i;
  assign periph_be_o  = 4'hF;
  assign periph_id_o  = id_q;
  assign job_id_o     = job_id_q;
  assign unused_rdata = ^periph_r_data_i[30:8];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_JOB_REGS; i++) regs_q[i] <= '0;
      nregs_q  <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      job_id_q <= '0;
      id_q     <= '0;
    end else begin
      if (granted) id_q <= id_q + 1'b1;
      if (clear_i) begin
        job_id_q <= '0;
      end else begin
        if (accept) begin
          for (int i = 0; i < N_JOB_REGS; i++)
            regs_q[i] <= job_regs_i[32*i +: 32];
          nregs_q <= (job_nregs_i > NMAX) ? NMAX : job_nregs_i;
        end
        if (state_q == DS_ACQ_RSP && periph_r_valid_i) begin
          cnt_q <= CW'(BACKOFF_CYC);
          idx_q <= '0;
          if (!periph_r_data_i[31]) job_id_q <= periph_r_data_i[7:0];
        end
        if (state_q == DS_BACKOFF) cnt_q <= cnt_q - 1'b1;
        if (state_q == DS_WR_RSP && periph_r_valid_i) idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_job_dispatcher.sv
// Directed bench for hwpe_ctrl_job_dispatcher: slave model, job scoreboard
// and per-cycle protocol checks; honours HWPE_CTRL_DISPATCH_WAIT_EN.
module tb_hwpe_ctrl_job_dispatcher;

  localparam int N = 16;
  localparam int NW = $clog2(N + 1);
  localparam int BACKOFF = 8;
  localparam logic [31:0] BASE = 32'h1A10_0000;
`ifdef HWPE_CTRL_DISPATCH_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [31:0] data;
  } txn_t;

  logic clk_i, rst_ni, clear_i, job_valid_i, job_ready_o;
  logic [31:0] base_addr_i;
  logic [NW-1:0] job_nregs_i;
  logic [N*32-1:0] job_regs_i;
  logic periph_req_o, periph_gnt_i, periph_wen_o, periph_r_valid_i;
  logic [31:0] periph_add_o, periph_data_o, periph_r_data_i;
  logic [3:0] periph_be_o;
  logic [7:0] periph_id_o, job_id_o;
  logic busy_o, done_o, gnt_en;

  hwpe_ctrl_job_dispatcher #(
    .N_JOB_REGS(N), .JOB_BASE_OFFS(32'h20),
    .BACKOFF_CYC(BACKOFF), .ID_WIDTH(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .base_addr_i(base_addr_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_nregs_i(job_nregs_i), .job_regs_i(job_regs_i),
    .periph_req_o(periph_req_o), .periph_gnt_i(periph_gnt_i),
    .periph_add_o(periph_add_o), .periph_wen_o(periph_wen_o),
    .periph_be_o(periph_be_o), .periph_data_o(periph_data_o),
    .periph_id_o(periph_id_o),
    .periph_r_valid_i(periph_r_valid_i), .periph_r_data_i(periph_r_data_i),
    .busy_o(busy_o), .job_id_o(job_id_o), .done_o(done_o)
  );

  assign periph_gnt_i = periph_req_o & gnt_en;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  txn_t exp_q[$];
  logic [31:0] acq_q[$], st_q[$];
  int acq_cyc[$];
  logic [31:0] vals [N];
  logic [7:0] exp_jobid, done_jobid;
  int exp_lat, acc_cyc, done_cyc, done_cnt, wr_cnt, status_reads;
  int gnt_delay = 0, rv_delay = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic txn_t mk(input logic [31:0] a, input logic w,
                              input logic [31:0] d);
    txn_t t;
    t.add = a; t.wen = w; t.data = d;
    return t;
  endfunction

  // Expected bus traffic of one job, derived from the acquire/status replies
  task automatic model_job(input int k);
    int kk, np;
    kk = (k > N) ? N : k;
    exp_lat = 0;
    for (int a = 0; a < acq_q.size(); a++) begin
      exp_q.push_back(mk(BASE + 32'h4, 1'b1, 32'h0));
      if (acq_q[a][31]) continue;
      exp_jobid = acq_q[a][7:0];
      for (int i = 0; i < kk; i++)
        exp_q.push_back(mk(BASE + 32'h20 + 32'(4 * i), 1'b0, vals[i]));
      exp_q.push_back(mk(BASE, 1'b0, 32'h0));
      np = 0;
      if (WAIT_EN) begin
        np = st_q.size() + 1;
        for (int s = st_q.size() - 1; s >= 0; s--)
          if (st_q[s] == 0) np = s + 1;
        for (int s = 0; s < np; s++)
          exp_q.push_back(mk(BASE + 32'hC, 1'b1, 32'h0));
      end
      exp_lat = 2 * (kk + 2) + 1 + 2 * np;
      break;
    end
  endtask

  // Slave model and compare process
  bit pend = 0, p_req = 0, p_gnt = 0, p_wen = 1, p_done = 0;
  int rv_wait = 0, gnt_wait = 0;
  logic [31:0] p_add, p_data, rsp;
  logic [7:0] p_id, id_model;
  txn_t e;

  initial begin
    gnt_en = 1'b0; periph_r_valid_i = 1'b0; periph_r_data_i = '0;
    rsp = '0; p_add = '0; p_data = '0; p_id = '0; id_model = '0;
    forever begin
      @(negedge clk_i);
      if (pend && rv_wait >= rv_delay) begin
        periph_r_valid_i = 1'b1; periph_r_data_i = rsp;
      end else begin
        periph_r_valid_i = 1'b0; periph_r_data_i = '0;
        if (pend) rv_wait++;
      end
      gnt_en = !pend && (gnt_wait >= gnt_delay);
      #4;
      if (!rst_ni) begin
        pend = 0; gnt_wait = 0; id_model = '0; p_req = 0; p_done = 0;
        continue;
      end
      chk("be_const", 32'(periph_be_o), 32'hF);
      if (pend) chk("single_outstanding", 32'(periph_req_o), 32'h0);
      if (p_req && !p_gnt && !clear_i) begin
        chk("req_held", 32'(periph_req_o), 32'h1);
        chk("add_held", periph_add_o, p_add);
        chk("wen_held", 32'(periph_wen_o), 32'(p_wen));
        chk("data_held", periph_data_o, p_data);
        chk("id_held", 32'(periph_id_o), 32'(p_id));
      end
      if (done_o) begin
        chk("done_one_cycle", 32'(p_done), 32'h0);
        chk("done_txn_left", 32'(exp_q.size()), 32'h0);
        chk("done_job_id", 32'(job_id_o), 32'(exp_jobid));
        done_jobid = job_id_o;
        done_cnt++;
        done_cyc = cyc;
      end
      if (periph_r_valid_i) pend = 0;
      p_gnt = periph_req_o && periph_gnt_i;
      if (p_gnt) begin
        chk("txn_id", 32'(periph_id_o), 32'(id_model));
        id_model++;
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_txn: got add %h wen %b, required none",
                   periph_add_o, periph_wen_o);
        end else begin
          e = exp_q.pop_front();
          chk("txn_add", periph_add_o, e.add);
          chk("txn_wen", 32'(periph_wen_o), 32'(e.wen));
          if (!e.wen) chk("txn_data", periph_data_o, e.data);
        end
        rsp = '0;
        if (periph_wen_o && periph_add_o == BASE + 32'h4) begin
          acq_cyc.push_back(cyc);
          rsp = (acq_q.size() != 0) ? acq_q.pop_front() : 32'h2;
        end else if (periph_wen_o && periph_add_o == BASE + 32'hC) begin
          status_reads++;
          rsp = (st_q.size() != 0) ? st_q.pop_front() : 32'h0;
        end else if (!periph_wen_o && periph_add_o >= BASE + 32'h20) begin
          wr_cnt++;
        end
        pend = 1; rv_wait = 0; gnt_wait = 0;
      end else if (periph_req_o) begin
        gnt_wait++;
      end else begin
        gnt_wait = 0;
      end
      p_req = periph_req_o; p_add = periph_add_o; p_wen = periph_wen_o;
      p_data = periph_data_o; p_id = periph_id_o; p_done = done_o;
    end
  end

  task automatic offer(input int k);
    bit ok;
    ok = 0;
    wr_cnt = 0;
    @(negedge clk_i);
    job_valid_i = 1'b1;
    job_nregs_i = NW'(k);
    for (int i = 0; i < N; i++) job_regs_i[32*i +: 32] = vals[i];
    for (int t = 0; t < 50 && !ok; t++) begin
      #4;
      if (job_ready_o) begin ok = 1; acc_cyc = cyc; end
      else @(negedge clk_i);
    end
    chk("job_accepted", 32'(ok), 32'h1);
    @(negedge clk_i);
    job_valid_i = 1'b0;
  endtask

  task automatic finish_job(input string name);
    int d0;
    d0 = done_cnt;
    for (int t = 0; t < 400 && done_cnt == d0; t++) @(negedge clk_i);
    chk({name, "_done"}, 32'(done_cnt - d0), 32'h1);
    repeat (3) @(negedge clk_i);
    chk({name, "_done_once"}, 32'(done_cnt - d0), 32'h1);
    chk({name, "_all_txns"}, 32'(exp_q.size()), 32'h0);
    chk({name, "_idle"}, 32'(busy_o), 32'h0);
  endtask

  task automatic set_vals(input logic [31:0] seed);
    for (int i = 0; i < N; i++) vals[i] = seed ^ (32'(i) * 32'h0101_0101);
  endtask

  initial begin
    int d0;
    rst_ni = 1'b0; clear_i = 1'b0; job_valid_i = 1'b0;
    base_addr_i = BASE; job_nregs_i = '0; job_regs_i = '0;
    done_cnt = 0; status_reads = 0; wr_cnt = 0;
    repeat (3) @(negedge clk_i);
    #4;
    chk("rst_req", 32'(periph_req_o), 32'h0);
    chk("rst_add", periph_add_o, 32'h0);
    chk("rst_wen", 32'(periph_wen_o), 32'h1);
    chk("rst_be", 32'(periph_be_o), 32'hF);
    chk("rst_data", periph_data_o, 32'h0);
    chk("rst_id", 32'(periph_id_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_job_id", 32'(job_id_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_ready", 32'(job_ready_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // clear_i beats a same-cycle job offer
    job_valid_i = 1'b1; clear_i = 1'b1; job_nregs_i = NW'(1);
    #4;
    chk("clr_blocks_ready", 32'(job_ready_o), 32'h0);
    @(negedge clk_i);
    job_valid_i = 1'b0; clear_i = 1'b0;
    #4;
    chk("clr_no_accept", 32'(busy_o), 32'h0);

    // 1: three registers, zero-wait slave
    vals[0] = 32'hAAAA_AAAA; vals[1] = 32'hBBBB_BBBB; vals[2] = 32'hCCCC_CCCC;
    acq_q = '{32'h2};
    model_job(3);
    chk("t1_model_len", 32'(exp_q.size()), WAIT_EN ? 32'd6 : 32'd5);
    chk("t1_model_wr0", exp_q[1].add, BASE + 32'h20);
    chk("t1_model_wr2", exp_q[3].add, BASE + 32'h28);
    chk("t1_model_c", exp_q[3].data, 32'hCCCC_CCCC);
    chk("t1_model_trig", exp_q[4].add, BASE);
    chk("t1_model_lat", 32'(exp_lat), WAIT_EN ? 32'd13 : 32'd11);
    offer(3);
    finish_job("t1");
    chk("t1_latency", 32'(done_cyc - acc_cyc), 32'(exp_lat));
    chk("t1_job_id", 32'(done_jobid), 32'h2);

    // 2: two failed acquires with back-off
    set_vals(32'h1234_5678);
    acq_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1};
    acq_cyc.delete();
    model_job(2);
    offer(2);
    finish_job("t2");
    chk("t2_acq_reads", 32'(acq_cyc.size()), 32'd3);
    for (int i = 1; i < acq_cyc.size(); i++)
      chk("t2_backoff_gap",
          32'((acq_cyc[i] - acq_cyc[i-1] - 1) >= BACKOFF), 32'h1);
    chk("t2_job_id", 32'(done_jobid), 32'h1);

    // 3: no registers, then more registers than the block holds
    acq_q = '{32'h5};
    model_job(0);
    offer(0);
    finish_job("t3a");
    chk("t3a_latency", 32'(done_cyc - acc_cyc), WAIT_EN ? 32'd7 : 32'd5);
    set_vals(32'h0F0F_0000);
    acq_q = '{32'h7};
    model_job(N + 5);
    offer(N + 5);
    finish_job("t3b");
    chk("t3b_writes", 32'(wr_cnt), 32'd16);
    chk("t3b_latency", 32'(done_cyc - acc_cyc), WAIT_EN ? 32'd39 : 32'd37);

    // 4: slow slave
    gnt_delay = 3; rv_delay = 2;
    set_vals(32'hDEAD_0000);
    acq_q = '{32'h3};
    model_job(2);
    offer(2);
    finish_job("t4");
    gnt_delay = 0;

    // 5: abort after the second write is granted
    set_vals(32'h5555_0000);
    acq_q = '{32'h4};
    model_job(3);
    offer(3);
    for (int t = 0; t < 100 && wr_cnt < 2; t++) @(negedge clk_i);
    clear_i = 1'b1;
    exp_q.delete();
    d0 = done_cnt;
    @(negedge clk_i);
    clear_i = 1'b0;
    #4;
    chk("t5_draining", 32'(busy_o), 32'h1);
    chk("t5_job_id_clr", 32'(job_id_o), 32'h0);
    for (int t = 0; t < 20 && busy_o; t++) begin
      @(negedge clk_i);
      #4;
    end
    chk("t5_idle", 32'(busy_o), 32'h0);
    chk("t5_rsp_taken", 32'(pend), 32'h0);
    repeat (4) @(negedge clk_i);
    chk("t5_no_done", 32'(done_cnt - d0), 32'h0);
    rv_delay = 0;

    // 6: STATUS polling (only when enabled)
    set_vals(32'h6666_0000);
    acq_q = '{32'h6};
    st_q = '{32'h1, 32'h1, 32'h0};
    status_reads = 0;
    model_job(1);
    offer(1);
    finish_job("t6");
    chk("t6_status_reads", 32'(status_reads), WAIT_EN ? 32'd3 : 32'd0);
    st_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
